// File: rtl/div_issue_queue.sv
// div_issue_queue: front end of the iterative divider. It buffers DIV/DIVU/REM/REMU operands,
//   issues them one at a time to the divider, and returns results to writeback in program order.
// Latency: an accepted request is visible on div_valid_o one cycle later. A local completion
//   (illegal funct3 or fast path) is visible on wb_valid_o one cycle after accept if it is at the head.
//   A divider result passes combinationally from divres_* to wb_*.
// Backpressure: req_ready_o depends only on registered occupancy, so there is no pop-through when full.
//   divres_ready_o follows wb_ready_o while a divider op is at the head of the order queue.
//
// Optional feature macro: DIVQ_FASTPATH_EN. When it is defined, valid requests with trivial
//   operands are completed locally at accept time: b==0, then b==1, then a==0.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req_*_i / req_ready_o     EXU request {funct3, a, b, tag}, valid/ready
//   div_*_o / div_ready_i     operand issue to the divider; the opcode is funct3[1:0]
//                             (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   divres_*                  divider result, valid/ready
//   wb_*                      in-order writeback {data, tag}, valid/ready
//   busy_o                    order queue non-empty
// Parameters: RQ_DEPTH and OQ_DEPTH must be powers of two and at least 2, with OQ_DEPTH >= RQ_DEPTH.
module div_issue_queue #(
  parameter int RQ_DEPTH = 4,
  parameter int OQ_DEPTH = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  // request from EXU issue stage
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  // issue to divider
  output logic             div_valid_o,
  input  logic             div_ready_i,
  output logic [31:0]      div_dataA_o,
  output logic [31:0]      div_dataB_o,
  output logic [1:0]       div_opcode_o,
  // divider result
  input  logic             divres_valid_i,
  output logic             divres_ready_o,
  input  logic [31:0]      divres_data_i,
  // writeback
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_data_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             busy_o
);

  localparam int RQ_PW = $clog2(RQ_DEPTH);
  localparam int RQ_CW = RQ_PW + 1;
  localparam int OQ_PW = $clog2(OQ_DEPTH);
  localparam int OQ_CW = OQ_PW + 1;

  localparam logic [RQ_PW-1:0] RQ_PTR_ONE  = RQ_PW'(1);
  localparam logic [RQ_CW-1:0] RQ_CNT_ONE  = RQ_CW'(1);
  localparam logic [RQ_CW-1:0] RQ_CNT_FULL = RQ_CW'(RQ_DEPTH);
  localparam logic [OQ_PW-1:0] OQ_PTR_ONE  = OQ_PW'(1);
  localparam logic [OQ_CW-1:0] OQ_CNT_ONE  = OQ_CW'(1);
  localparam logic [OQ_CW-1:0] OQ_CNT_FULL = OQ_CW'(OQ_DEPTH);

  localparam logic [31:0] ILLEGAL_RES = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // ---------------------------------------------------------------------------
  // Storage. Entries are only written on push. Reset clears the pointers and
  // counters, so a stale entry is never read.
  // ---------------------------------------------------------------------------
  logic [31:0]      rq_a_q   [RQ_DEPTH];
  logic [31:0]      rq_b_q   [RQ_DEPTH];
  div_op_e          rq_op_q  [RQ_DEPTH];
  logic [TAG_W-1:0] oq_tag_q [OQ_DEPTH];
  logic             oq_loc_q [OQ_DEPTH];
  logic [31:0]      oq_res_q [OQ_DEPTH];

  logic [RQ_PW-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic [RQ_CW-1:0] rq_cnt_q, rq_cnt_d;
  logic [OQ_PW-1:0] oq_wr_q, oq_wr_d, oq_rd_q, oq_rd_d;
  logic [OQ_CW-1:0] oq_cnt_q, oq_cnt_d;

  logic        rq_full, rq_empty, oq_full, oq_empty;
  logic        req_fire, rq_push, rq_pop, oq_push, oq_pop;
  logic        req_local;
  logic [31:0] req_res;
  div_op_e     req_op;
  logic        head_loc;

  assign rq_full  = (rq_cnt_q == RQ_CNT_FULL);
  assign rq_empty = (rq_cnt_q == '0);
  assign oq_full  = (oq_cnt_q == OQ_CNT_FULL);
  assign oq_empty = (oq_cnt_q == '0);

  // Readiness is based on registered state only. A writeback pop in the same
  // cycle does not open a slot until the next cycle.
  assign req_ready_o = !oq_full && !rq_full;
  assign req_fire    = req_valid_i && req_ready_o;
  assign req_op      = div_op_e'(req_funct3_i[1:0]);

  // ---------------------------------------------------------------------------
  // Local-completion decode. An illegal funct3 (bit2 clear) never reaches the
  // divider. With the fast path enabled, trivial operand cases also complete
  // locally. Their order of precedence is b==0, then b==1, then a==0.
  // ---------------------------------------------------------------------------
`ifdef DIVQ_FASTPATH_EN
  logic req_is_rem;
  assign req_is_rem = (req_op == OP_REM) || (req_op == OP_REMU);
`endif

  always_comb begin
    req_local = 1'b0;
    req_res   = '0;
    if (!req_funct3_i[2]) begin
      req_local = 1'b1;
      req_res   = ILLEGAL_RES;
    end
`ifdef DIVQ_FASTPATH_EN
    else if (req_b_i == 32'd0) begin
      req_local = 1'b1;
      req_res   = req_is_rem ? req_a_i : 32'hFFFF_FFFF;
    end else if (req_b_i == 32'd1) begin
      req_local = 1'b1;
      req_res   = req_is_rem ? 32'd0 : req_a_i;
    end else if (req_a_i == 32'd0) begin
      req_local = 1'b1;
      req_res   = 32'd0;
    end
`endif
  end

  // Every accepted op reserves its program-order slot. Only divider work
  // takes a slot in the operand queue.
  assign oq_push = req_fire;
  assign rq_push = req_fire && !req_local;

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  assign div_valid_o  = !rq_empty;
  assign rq_pop       = div_valid_o && div_ready_i;
  assign div_dataA_o  = div_valid_o ? rq_a_q[rq_rd_q] : '0;
  assign div_dataB_o  = div_valid_o ? rq_b_q[rq_rd_q] : '0;
  assign div_opcode_o = div_valid_o ? rq_op_q[rq_rd_q] : 2'b00;

  // ---------------------------------------------------------------------------
  // Completion side. The oq head decides where the writeback data comes from.
  // A local op waits behind an outstanding divider op, even if its result is
  // already known.
  // ---------------------------------------------------------------------------
  assign head_loc = oq_loc_q[oq_rd_q];

  always_comb begin
    wb_valid_o     = 1'b0;
    wb_data_o      = '0;
    wb_tag_o       = '0;
    divres_ready_o = 1'b0;
    if (!oq_empty) begin
      if (head_loc) begin
        wb_valid_o = 1'b1;
        wb_data_o  = oq_res_q[oq_rd_q];
      end else begin
        wb_valid_o     = divres_valid_i;
        wb_data_o      = divres_valid_i ? divres_data_i : '0;
        divres_ready_o = wb_ready_i;
      end
      if (wb_valid_o) begin
        wb_tag_o = oq_tag_q[oq_rd_q];
      end
    end
  end

  assign oq_pop = wb_valid_o && wb_ready_i;
  assign busy_o = !oq_empty;

  // ---------------------------------------------------------------------------
  // Pointer and occupancy next state. Depths are powers of two, so the
  // pointers wrap naturally.
  // ---------------------------------------------------------------------------
  always_comb begin
    rq_wr_d  = rq_wr_q;
    rq_rd_d  = rq_rd_q;
    rq_cnt_d = rq_cnt_q;
    oq_wr_d  = oq_wr_q;
    oq_rd_d  = oq_rd_q;
    oq_cnt_d = oq_cnt_q;

    if (rq_push) rq_wr_d = rq_wr_q + RQ_PTR_ONE;
    if (rq_pop)  rq_rd_d = rq_rd_q + RQ_PTR_ONE;
    case ({rq_push, rq_pop})
      2'b10:   rq_cnt_d = rq_cnt_q + RQ_CNT_ONE;
      2'b01:   rq_cnt_d = rq_cnt_q - RQ_CNT_ONE;
      default: rq_cnt_d = rq_cnt_q;
    endcase

    if (oq_push) oq_wr_d = oq_wr_q + OQ_PTR_ONE;
    if (oq_pop)  oq_rd_d = oq_rd_q + OQ_PTR_ONE;
    case ({oq_push, oq_pop})
      2'b10:   oq_cnt_d = oq_cnt_q + OQ_CNT_ONE;
      2'b01:   oq_cnt_d = oq_cnt_q - OQ_CNT_ONE;
      default: oq_cnt_d = oq_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_wr_q  <= '0;
      rq_rd_q  <= '0;
      rq_cnt_q <= '0;
      oq_wr_q  <= '0;
      oq_rd_q  <= '0;
      oq_cnt_q <= '0;
    end else begin
      rq_wr_q  <= rq_wr_d;
      rq_rd_q  <= rq_rd_d;
      rq_cnt_q <= rq_cnt_d;
      oq_wr_q  <= oq_wr_d;
      oq_rd_q  <= oq_rd_d;
      oq_cnt_q <= oq_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_a_q[rq_wr_q]  <= req_a_i;
      rq_b_q[rq_wr_q]  <= req_b_i;
      rq_op_q[rq_wr_q] <= req_op;
    end
    if (oq_push) begin
      oq_tag_q[oq_wr_q] <= req_tag_i;
      oq_loc_q[oq_wr_q] <= req_local;
      oq_res_q[oq_wr_q] <= req_res;
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// tb_div_issue_queue: self-checking bench for div_issue_queue.
// Drives directed scenarios and then a random phase. It keeps an in-order reference
// model and a behavioural divider with variable latency.
module tb_div_issue_queue;

  localparam int RQ_DEPTH = 4;
  localparam int OQ_DEPTH = 4;
  localparam int TAG_W    = 5;
`ifdef DIVQ_FASTPATH_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_funct3 = 3'b0;
  logic [31:0]      req_a = 32'b0;
  logic [31:0]      req_b = 32'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             div_valid;
  logic             div_ready = 1'b0;
  logic [31:0]      div_dataA, div_dataB;
  logic [1:0]       div_opcode;
  logic             divres_valid = 1'b0;
  logic             divres_ready;
  logic [31:0]      divres_data = 32'b0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             busy;

  always #5 clk = ~clk;

  div_issue_queue #(.RQ_DEPTH(RQ_DEPTH), .OQ_DEPTH(OQ_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .div_valid_o(div_valid), .div_ready_i(div_ready), .div_dataA_o(div_dataA),
    .div_dataB_o(div_dataB), .div_opcode_o(div_opcode),
    .divres_valid_i(divres_valid), .divres_ready_o(divres_ready), .divres_data_i(divres_data),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_tag_o(wb_tag),
    .busy_o(busy)
  );

  typedef struct packed { logic [TAG_W-1:0] tag; logic loc; logic [31:0] res; } oq_ent_t;
  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [1:0] op; } iss_t;
  typedef struct packed { logic [TAG_W-1:0] tag; logic [31:0] data; } wb_t;

  oq_ent_t     exp_oq[$];   // program order of outstanding ops
  iss_t        exp_iq[$];   // divider work not yet issued
  logic [31:0] dv_q[$];     // results held inside the behavioural divider
  wb_t         wb_log[$];   // observed writebacks

  int checks = 0;
  int errors = 0;
  int cyc = 0, tick_id = 0, div_issues = 0;
  int dv_wait = 0, lat_max = 2, div_rdy_mode = 1, wb_rdy_mode = 1;
  logic spur = 1'b0;
  logic last_acc, last_wbf;
  logic t_v = 1'b0;
  logic [2:0] t_f3 = 3'b0;
  logic [31:0] t_a = 32'b0, t_b = 32'b0;
  logic [TAG_W-1:0] t_tag = '0;
  logic s_req_ready, s_div_valid, s_wb_valid, s_busy;
  logic [1:0] s_div_opcode;
  logic [31:0] s_wb_data;
  logic [TAG_W-1:0] s_wb_tag;

  // RISC-V M-extension semantics, computed arithmetically
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!f3[2]) return 32'hDEAD_BEEF;
    case (f3[1:0])
      2'b00:   if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return sa / sb;
      2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'b10:   if (b == 0) return a; else if (ovf) return 32'd0; else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic logic is_local_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return !f3[2] || (FP_EN && (b == 0 || b == 1 || a == 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    chk(name, 32'(obs), 32'(exp));
  endtask

  // One clock cycle. Inputs change at the falling edge, outputs are checked
  // against the model #1 later, and the model advances at the rising edge.
  task automatic tick();
    logic acc, iss, rsp, wbf, ewv;
    oq_ent_t oe;
    iss_t ie;
    @(negedge clk);
    req_valid  = t_v;
    req_funct3 = t_f3;
    req_a      = t_a;
    req_b      = t_b;
    req_tag    = t_tag;
    div_ready  = (div_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (div_rdy_mode == 1);
    wb_ready   = (wb_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (wb_rdy_mode == 1);
    if (spur) begin
      divres_valid = 1'b1;
      divres_data  = 32'h0BAD_0BAD;
    end else begin
      divres_valid = (dv_q.size() != 0) && (dv_wait == 0);
      divres_data  = divres_valid ? dv_q[0] : 32'h0;
    end
    #1;
    s_req_ready = req_ready; s_div_valid = div_valid; s_div_opcode = div_opcode;
    s_wb_valid = wb_valid; s_wb_data = wb_data; s_wb_tag = wb_tag; s_busy = busy;

    chk1("req_ready", req_ready, (exp_oq.size() < OQ_DEPTH) && (exp_iq.size() < RQ_DEPTH));
    chk1("busy", busy, exp_oq.size() != 0);
    chk1("div_valid", div_valid, exp_iq.size() != 0);
    if (exp_iq.size() != 0) begin
      chk("div_dataA", div_dataA, exp_iq[0].a);
      chk("div_dataB", div_dataB, exp_iq[0].b);
      chk("div_opcode", 32'(div_opcode), 32'(exp_iq[0].op));
    end else begin
      chk("div_idle_data", div_dataA | div_dataB | 32'(div_opcode), 32'h0);
    end
    if (exp_oq.size() == 0) ewv = 1'b0;
    else if (exp_oq[0].loc) ewv = 1'b1;
    else ewv = divres_valid;
    chk1("wb_valid", wb_valid, ewv);
    if (ewv) begin
      chk("wb_tag", 32'(wb_tag), 32'(exp_oq[0].tag));
      chk("wb_data", wb_data, exp_oq[0].res);
    end else begin
      chk("wb_idle", wb_data | 32'(wb_tag), 32'h0);
    end
    chk1("divres_ready", divres_ready,
         (exp_oq.size() != 0) && !exp_oq[0].loc && wb_ready);

    acc = req_valid && req_ready;
    iss = div_valid && div_ready;
    rsp = divres_valid && divres_ready;
    wbf = wb_valid && wb_ready;
    last_acc = acc;
    last_wbf = wbf;
    tick_id  = cyc;

    @(posedge clk);
    if (wbf && exp_oq.size() != 0) begin
      wb_log.push_back({s_wb_tag, s_wb_data});
      void'(exp_oq.pop_front());
    end
    if (dv_wait > 0) dv_wait--;
    if (rsp && dv_q.size() != 0) begin
      void'(dv_q.pop_front());
      dv_wait = $urandom_range(0, lat_max);
    end
    if (iss && exp_iq.size() != 0) begin
      ie = exp_iq.pop_front();
      if (dv_q.size() == 0) dv_wait = $urandom_range(0, lat_max);
      dv_q.push_back(ref_res({1'b1, ie.op}, ie.a, ie.b));
      div_issues++;
    end
    if (acc) begin
      oe.tag = req_tag;
      oe.loc = is_local_ref(req_funct3, req_a, req_b);
      oe.res = ref_res(req_funct3, req_a, req_b);
      exp_oq.push_back(oe);
      if (!oe.loc) begin
        ie.a = req_a; ie.b = req_b; ie.op = req_funct3[1:0];
        exp_iq.push_back(ie);
      end
    end
    cyc++;
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    t_v = 1'b1; t_f3 = f3; t_a = a; t_b = b; t_tag = tag;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 300);
    t_v = 1'b0;
    checks++;
    assert (last_acc) else begin
      errors++;
      $error("FAIL send_timeout observed=not-accepted expected=accepted tag=%0d", tag);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    t_v = 1'b0;
    while (exp_oq.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_oq.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_oq.size());
    end
  endtask

  task automatic chk_log(input int idx, input logic [TAG_W-1:0] tag, input logic [31:0] data);
    if (wb_log.size() > idx) begin
      chk("log_tag", 32'(wb_log[idx].tag), 32'(tag));
      chk("log_data", wb_log[idx].data, data);
    end else begin
      chk("log_missing", 32'(wb_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; t_v = 1'b0; req_valid = 1'b0; divres_valid = 1'b0; spur = 1'b0;
    @(posedge clk);
    @(posedge clk);
    exp_oq.delete(); exp_iq.delete(); dv_q.delete(); dv_wait = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_div_valid", div_valid, 1'b0);
    chk1("rst_divres_ready", divres_ready, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_zero_data", wb_data | 32'(wb_tag) | div_dataA | div_dataB | 32'(div_opcode), 32'h0);
  endtask

  initial begin
    #400000;
    $fatal(1, "FAIL watchdog observed=timeout expected=finish");
  end

  initial begin
    int pop_c, acc_c, n, iss0;
    logic [2:0] f3;

    // Reset, then a single DIVU.
    do_reset();
    wb_log.delete(); div_rdy_mode = 1; wb_rdy_mode = 1; lat_max = 2;
    send(3'b101, 32'd100, 32'd7, 5'd3);
    chk1("t1_div_valid_N", s_div_valid, 1'b0);
    tick();
    chk1("t1_div_valid_N1", s_div_valid, 1'b1);
    chk("t1_opcode", 32'(s_div_opcode), 32'd1);
    drain(100);
    chk("t1_nwb", 32'(wb_log.size()), 32'd1);
    chk_log(0, 5'd3, 32'd14);
    tick();
    chk1("t1_busy_idle", s_busy, 1'b0);

    // Back-to-back signed REM and the DIV overflow case.
    wb_log.delete();
    send(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1);
    send(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    drain(100);
    chk_log(0, 5'd1, 32'hFFFF_FFFF);
    chk_log(1, 5'd2, 32'h8000_0000);

    // Fill both queues while the divider stalls, then hold a 5th request.
    wb_log.delete(); div_rdy_mode = 0; wb_rdy_mode = 1;
    for (int i = 0; i < 4; i++) send(3'b100, 32'd1000 + 32'(i), 32'd7, 5'(10 + i));
    tick();
    chk1("t3_full", s_req_ready, 1'b0);
    t_v = 1'b1; t_f3 = 3'b100; t_a = 32'd2000; t_b = 32'd9; t_tag = 5'd14;
    div_rdy_mode = 1;
    pop_c = -1; acc_c = -1; n = 0;
    while (acc_c < 0 && n < 200) begin
      tick();
      if (last_wbf && pop_c < 0) pop_c = tick_id;
      if (last_acc) acc_c = tick_id;
      n++;
    end
    t_v = 1'b0;
    chk("t3_accept_after_pop", 32'(acc_c), 32'(pop_c + 1));
    drain(200);
    chk("t3_nwb", 32'(wb_log.size()), 32'd5);
    chk_log(4, 5'd14, 32'd222);

    // Illegal funct3 waits behind a pending DIV and bypasses the divider.
    wb_log.delete(); div_rdy_mode = 0;
    iss0 = div_issues;
    send(3'b100, 32'd1000, 32'd10, 5'd8);
    send(3'b011, 32'd5, 32'd6, 5'd9);
    tick();
    tick();
    chk1("t4_local_waits", s_wb_valid, 1'b0);
    div_rdy_mode = 1;
    drain(100);
    chk("t4_div_issues", 32'(div_issues - iss0), 32'd1);
    chk_log(0, 5'd8, 32'd100);
    chk_log(1, 5'd9, 32'hDEAD_BEEF);

`ifdef DIVQ_FASTPATH_EN
    // Trivial operands complete locally one cycle after accept.
    wb_log.delete(); iss0 = div_issues;
    send(3'b100, 32'd55, 32'd1, 5'd4);
    tick();
    chk1("fp_div_idle", s_div_valid, 1'b0);
    chk1("fp_wb_valid", s_wb_valid, 1'b1);
    chk("fp_wb_data", s_wb_data, 32'd55);
    chk("fp_wb_tag", 32'(s_wb_tag), 32'd4);
    send(3'b111, 32'd9, 32'd0, 5'd5);
    drain(50);
    chk_log(1, 5'd5, 32'd9);
    chk("fp_no_issue", 32'(div_issues - iss0), 32'd0);
`endif

    // Reset while a divider op is outstanding and writeback is stalled.
    wb_log.delete(); div_rdy_mode = 1; wb_rdy_mode = 0; lat_max = 40;
    send(3'b101, 32'd77, 32'd5, 5'd6);
    tick();
    tick();
    do_reset();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk1("t6_spurious_ignored", s_wb_valid, 1'b0);
    lat_max = 2; wb_rdy_mode = 1;
    send(3'b101, 32'd10, 32'd3, 5'd7);
    drain(100);
    chk("t6_nwb", 32'(wb_log.size()), 32'd1);
    chk_log(0, 5'd7, 32'd3);

    // Random traffic with random backpressure on every interface.
    wb_log.delete(); div_rdy_mode = 2; wb_rdy_mode = 2; lat_max = 3;
    for (int i = 0; i < 150; i++) begin
      f3 = {($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) tick();
      send(f3, pick(), pick(), TAG_W'($urandom_range(0, 31)));
    end
    drain(3000);
    chk("rnd_nwb", 32'(wb_log.size()), 32'd150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- Upstream front end of the iterative divider. Accepts RISC-V M-extension DIV/DIVU/REM/REMU requests from the EXU issue stage and buffers their operands.
- Issues requests one at a time to the divider's stage_if slave port.
- Re-associates each divider result with its destination tag and presents results to writeback in strict program order.
- Illegal funct3 requests, and trivial cases when the optional feature is compiled in, complete locally without occupying the divider.

Parameters:
- RQ_DEPTH, 4: entries in the operand request queue; power of two, minimum 2.
- OQ_DEPTH, 4: entries in the completion-order queue; power of two, minimum 2, must be >= RQ_DEPTH.
- TAG_W, 5: width of the destination tag (rd index).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  queue can accept
- req_funct3  in  3  100=DIV 101=DIVU 110=REM 111=REMU
- req_a  in  32  rs1 value
- req_b  in  32  rs2 value
- req_tag  in  TAG_W  destination tag
- div_valid  out  1  request to divider valid
- div_ready  in  1  divider accepts
- div_dataA  out  32  dividend
- div_dataB  out  32  divisor
- div_opcode  out  riscv_div_op_e  DIV/DIVU/REM/REMU from exu_types_pkg
- divres_valid  in  1  divider result valid
- divres_ready  out  1  result consumed
- divres_data  in  32  divider result
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback accepts
- wb_data  out  32  result
- wb_tag  out  TAG_W  tag of result
- busy  out  1  any op outstanding (order queue non-empty)

Behaviour:
- Reset: rst is synchronous, active-high, on clk. Reset empties both queues and clears all pointers and counters. After reset: req_ready=1, div_valid=0, divres_ready=0, wb_valid=0, busy=0. wb_data, wb_tag, div_dataA, div_dataB and div_opcode read 0 while their valid is low.
- Accept:
  - A request fires when req_valid && req_ready.
  - req_ready = !oq_full && !rq_full. It is registered-state based, with no same-cycle pop-through when full.
  - Every accepted request pushes one order entry {tag, local flag, local result}.
  - Only non-local requests also push a request-queue entry {a, b, op}.
- Illegal funct3 (bit2=0): the request is accepted as local with result 32'hDEADBEEF.
- Issue:
  - div_valid = rq non-empty; div_* driven from the rq head register.
  - Pop when div_valid && div_ready. At most one issue per cycle.
  - An entry accepted in cycle N is visible on div_valid no earlier than N+1.
- Completion, evaluated at the oq head:
  - If the head is local: wb_valid=1, wb_data=local result, divres_ready=0.
  - If the head is non-local: wb_valid=divres_valid, wb_data=divres_data (combinational pass-through), divres_ready = wb_ready.
  - If the oq is empty: wb_valid=0 and divres_ready=0.
  - wb_tag = head tag. The head pops on wb_valid && wb_ready.
- Ordering: results leave in acceptance order. A local op behind a pending divider op waits, even if its result is ready.
- Simultaneous events:
  - Accept, issue and writeback can all occur in one cycle.
  - Occupancy counters update as push minus pop.
  - Pointers wrap modulo depth.
- Stability: once wb_valid or div_valid is asserted, the corresponding data and tag hold until handshake.
- Reset mid-operation: queues are flushed. The divider shares rst, so no stale result arrives. A divres_valid seen with the oq empty is never acknowledged.

Optional Feature:
- Macro: DIVQ_FASTPATH_EN.
- Defined: valid-funct3 requests with trivial operands are completed locally, with the result computed at accept time:
  - b==0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> a.
  - b==1: DIV/DIVU -> a; REM/REMU -> 0.
  - a==0 (b nonzero): result 0.
  - Priority is b==0 > b==1 > a==0.
- Undefined: all valid-funct3 requests go to the divider; only illegal funct3 completes locally.

Test Plan:
- Reset, then DIVU a=100 b=7 tag=3 with wb_ready=1 -> div_valid at N+1 with opcode DIVU; wb fires with data=14, tag=3; busy returns to 0.
- Back-to-back REM a=-7 b=2 (tag 1) and DIV a=0x80000000 b=0xFFFFFFFF (tag 2) -> wb order tag1=0xFFFFFFFF(-1), then tag2=0x80000000.
- Fill with 4 DIV requests while div_ready=0 -> req_ready drops after 4th accept; a 5th held request is accepted the cycle after the first wb pop frees an oq entry.
- funct3=3'b011 tag=9 queued behind a pending DIV tag=8 -> wb tag 8 first, then tag 9 with data 0xDEADBEEF; divider never sees the illegal op.
- With DIVQ_FASTPATH_EN: DIV a=55 b=1 tag=4 alone -> div_valid stays 0; wb data=55 tag=4 at N+1. REMU a=9 b=0 -> wb data=9.
- Assert rst while a divider op is outstanding with wb_ready=0 -> next cycle busy=0, wb_valid=0, req_ready=1; a new DIVU 10/3 then yields 3.
